// File: rtl/tri_pwm_deadtime.sv
`default_nettype none
// ============================================================================
// Module   : tri_pwm_deadtime
// Brief    : Triangle-carrier PWM comparator with peak/valley double-buffered
//            duty and complementary high/low gate drive separated by dead time.
// Revision : 1.0 - initial release
// ============================================================================
module tri_pwm_deadtime #(
  parameter int WIDTH       = 12,
  parameter int DEAD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] carrier,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ack,
  output logic             pwm_ref,
  output logic             sync_valley,
  output logic             out_hi,
  output logic             out_lo
);

  localparam logic [WIDTH-1:0] c_half    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0]       c_dt_last = 8'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DT_HI = 3'd1,
    S_HI    = 3'd2,
    S_DT_LO = 3'd3,
    S_LO    = 3'd4
  } state_t;

  logic [WIDTH-1:0] r_carrier_q;
  logic             r_dir_up;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_pending;
  state_t           r_state;
  logic [7:0]       r_dt_cnt;

  logic             w_gt;
  logic             w_lt;
  logic [WIDTH-1:0] w_diff;
  logic             w_wrap;
  logic             w_peak;
  logic             w_valley;
  logic             w_transfer;

  assign w_gt   = carrier > r_carrier_q;
  assign w_lt   = carrier < r_carrier_q;
  assign w_diff = w_gt ? (carrier - r_carrier_q) : (r_carrier_q - carrier);
  // A jump of more than half the range is the counter rolling over, not a slope.
  assign w_wrap = w_diff > c_half;

  assign w_peak     = w_lt & ~w_wrap &  r_dir_up;
  assign w_valley   = w_gt & ~w_wrap & ~r_dir_up;
  assign w_transfer = (w_peak | w_valley) & r_pending;

  assign pwm_ref = r_active > r_carrier_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carrier_q <= '0;
      r_dir_up    <= 1'b1;
      r_shadow    <= '0;
      r_active    <= '0;
      r_pending   <= 1'b0;
      duty_ack    <= 1'b0;
      sync_valley <= 1'b0;
    end else begin
      r_carrier_q <= carrier;
      if (!w_wrap) begin
        if (w_gt) begin
          r_dir_up <= 1'b1;
        end else if (w_lt) begin
          r_dir_up <= 1'b0;
        end
      end
      sync_valley <= w_valley;
      duty_ack    <= w_transfer;
      if (w_transfer) begin
        r_active <= r_shadow;
      end
      // A write colliding with a transfer keeps the new value pending.
      if (duty_valid) begin
        r_shadow  <= duty_in;
        r_pending <= 1'b1;
      end else if (w_transfer) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_dt_cnt <= '0;
      out_hi   <= 1'b0;
      out_lo   <= 1'b0;
    end else if (!enable) begin
      r_state  <= S_OFF;
      r_dt_cnt <= '0;
      out_hi   <= 1'b0;
      out_lo   <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_dt_cnt <= '0;
          out_hi   <= 1'b0;
          out_lo   <= 1'b0;
          r_state  <= pwm_ref ? S_DT_HI : S_DT_LO;
        end
        S_DT_HI: begin
          // Reference dropped before the gap elapsed: low side never turned off long.
          if (!pwm_ref) begin
            r_state <= S_LO;
            out_lo  <= 1'b1;
          end else if (r_dt_cnt == c_dt_last) begin
            r_state <= S_HI;
            out_hi  <= 1'b1;
          end else begin
            r_dt_cnt <= r_dt_cnt + 8'd1;
          end
        end
        S_HI: begin
          if (!pwm_ref) begin
            r_state  <= S_DT_LO;
            r_dt_cnt <= '0;
            out_hi   <= 1'b0;
          end
        end
        S_DT_LO: begin
          if (pwm_ref) begin
            r_state <= S_HI;
            out_hi  <= 1'b1;
          end else if (r_dt_cnt == c_dt_last) begin
            r_state <= S_LO;
            out_lo  <= 1'b1;
          end else begin
            r_dt_cnt <= r_dt_cnt + 8'd1;
          end
        end
        S_LO: begin
          if (pwm_ref) begin
            r_state  <= S_DT_HI;
            r_dt_cnt <= '0;
            out_lo   <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_OFF;
          r_dt_cnt <= '0;
          out_hi   <= 1'b0;
          out_lo   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_pwm_deadtime.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_pwm_deadtime
// Brief    : Self-checking bench for tri_pwm_deadtime against a run-length
//            behavioural model of the carrier, duty buffer and gate outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_pwm_deadtime;

  localparam int WIDTH = 12;
  localparam int DEAD  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] carrier;
  logic        enable;
  logic [11:0] duty_in;
  logic        duty_valid;
  logic        duty_ack;
  logic        pwm_ref;
  logic        sync_valley;
  logic        out_hi;
  logic        out_lo;

  always #5 clk = ~clk;

  tri_pwm_deadtime #(.WIDTH(WIDTH), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .carrier    (carrier),
    .enable     (enable),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ack   (duty_ack),
    .pwm_ref    (pwm_ref),
    .sync_valley(sync_valley),
    .out_hi     (out_hi),
    .out_lo     (out_lo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: carrier tracking and duty buffer as plain integers.
  int m_cq, m_active, m_shadow;
  bit m_pending, m_up, m_ack, m_sync;
  // Model: gate outputs from run lengths of the sampled reference.
  int m_run_hi, m_run_lo, m_side;  // side: 0 none, 1 hi, 2 lo
  bit m_hi, m_lo;

  // Observation counters.
  int ack_cnt, sync_cnt, hi_cnt, lo_cnt;
  bit gap_mon;
  int gap_len, last_side, gaps_seen;

  // Triangle generator state.
  int tri_val, tri_step, tri_hold, tri_top, hold_cnt;
  bit tri_up;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cq = 0; m_active = 0; m_shadow = 0;
    m_pending = 0; m_up = 1; m_ack = 0; m_sync = 0;
    m_run_hi = 0; m_run_lo = 0; m_side = 0; m_hi = 0; m_lo = 0;
  endtask

  task automatic model_edge();
    int  c, diff;
    bit  ref_pre, wrap, peak, valley, xfer;
    ref_pre = (m_active > m_cq);
    if (!enable) begin
      m_run_hi = 0; m_run_lo = 0; m_side = 0; m_hi = 0; m_lo = 0;
    end else begin
      // The first enabled sample decides which side an aborted gap falls back to.
      if (m_side == 0) m_side = ref_pre ? 2 : 1;
      if (ref_pre) begin m_run_hi++; m_run_lo = 0; end
      else         begin m_run_lo++; m_run_hi = 0; end
      if (m_run_hi >= DEAD + 1)          begin m_hi = 1; m_lo = 0; m_side = 1; end
      else if (m_run_lo >= DEAD + 1)     begin m_lo = 1; m_hi = 0; m_side = 2; end
      else if (m_side == 2 && !ref_pre)  begin m_lo = 1; m_hi = 0; end
      else if (m_side == 1 && ref_pre)   begin m_hi = 1; m_lo = 0; end
      else                               begin m_hi = 0; m_lo = 0; end
    end
    c      = int'(carrier);
    diff   = (c > m_cq) ? c - m_cq : m_cq - c;
    wrap   = diff > (1 << (WIDTH - 1));
    peak   = !wrap && (c < m_cq) && m_up;
    valley = !wrap && (c > m_cq) && !m_up;
    if (!wrap && c > m_cq) m_up = 1;
    else if (!wrap && c < m_cq) m_up = 0;
    xfer   = (peak || valley) && m_pending;
    m_ack  = xfer;
    m_sync = valley;
    if (xfer) m_active = m_shadow;
    if (duty_valid) begin m_shadow = int'(duty_in); m_pending = 1; end
    else if (xfer) m_pending = 0;
    m_cq = c;
  endtask

  task automatic step();
    int s;
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check("pwm_ref",     {31'd0, pwm_ref},     {31'd0, m_active > m_cq});
    check("duty_ack",    {31'd0, duty_ack},    {31'd0, m_ack});
    check("sync_valley", {31'd0, sync_valley}, {31'd0, m_sync});
    check("out_hi",      {31'd0, out_hi},      {31'd0, m_hi});
    check("out_lo",      {31'd0, out_lo},      {31'd0, m_lo});
    check("hi_lo_overlap", {31'd0, out_hi & out_lo}, 32'd0);
    if (duty_ack === 1'b1)    ack_cnt++;
    if (sync_valley === 1'b1) sync_cnt++;
    if (out_hi === 1'b1)      hi_cnt++;
    if (out_lo === 1'b1)      lo_cnt++;
    if (gap_mon) begin
      if (out_hi === 1'b1 || out_lo === 1'b1) begin
        s = (out_hi === 1'b1) ? 1 : 2;
        if (last_side != 0 && s != last_side) begin
          check("t1_dead_gap", 32'(gap_len), 32'(DEAD));
          gaps_seen++;
        end
        last_side = s;
        gap_len   = 0;
      end else begin
        gap_len++;
      end
    end
  endtask

  task automatic tick();
    hold_cnt++;
    if (hold_cnt >= tri_hold) begin
      hold_cnt = 0;
      if (tri_up) begin
        if (tri_val + tri_step > tri_top) begin tri_up = 0; tri_val -= tri_step; end
        else tri_val += tri_step;
      end else begin
        if (tri_val < tri_step) begin tri_up = 1; tri_val += tri_step; end
        else tri_val -= tri_step;
      end
    end
    carrier = 12'(tri_val);
  endtask

  task automatic advance_to(input int value, input bit up, input int maxn, input string name);
    bit found;
    int i;
    found = 0;
    i = 0;
    while (!found && i < maxn) begin
      tick();
      step();
      found = (int'(carrier) == value) && (tri_up == up);
      i++;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_low, hi_seen, zeros, lo_on, ref_ones, dis_left, pick;
    bit found;
    rst = 1; enable = 0; duty_valid = 0; duty_in = '0; carrier = '0;
    ack_cnt = 0; sync_cnt = 0; hi_cnt = 0; lo_cnt = 0;
    gap_mon = 0; gap_len = 0; last_side = 0; gaps_seen = 0;
    model_reset();
    repeat (3) step();
    check("reset_out_hi",   {31'd0, out_hi},      32'd0);
    check("reset_out_lo",   {31'd0, out_lo},      32'd0);
    check("reset_ack",      {31'd0, duty_ack},    32'd0);
    check("reset_sync",     {31'd0, sync_valley}, 32'd0);
    check("reset_pwm_ref",  {31'd0, pwm_ref},     32'd0);

    // T1: full-range triangle, duty at mid-scale.
    rst = 0; enable = 1;
    tri_val = 0; tri_up = 1; hold_cnt = 0; tri_step = 2; tri_hold = 2; tri_top = 'hFFE;
    duty_in = 12'h800; duty_valid = 1;
    tick(); step();
    duty_valid = 0;
    for (int i = 0; i < 8188; i++) begin tick(); step(); end
    hi_cnt = 0; lo_cnt = 0; gap_mon = 1; last_side = 0; gap_len = 0; gaps_seen = 0;
    for (int i = 0; i < 8188; i++) begin tick(); step(); end
    gap_mon = 0;
    check("t1_transitions", 32'(gaps_seen), 32'd2);
    check("t1_balance", {31'd0, (hi_cnt - lo_cnt <= 16) && (lo_cnt - hi_cnt <= 16)}, 32'd1);

    // T2: new duty written on the rising slope applies only from the peak.
    advance_to('h200, 1, 9000, "t2_reach_rise");
    ack_cnt = 0;
    duty_in = 12'h400; duty_valid = 1;
    tick(); step();
    duty_valid = 0;
    advance_to('h600, 1, 9000, "t2_reach_600_up");
    check("t2_old_duty_ref", {31'd0, pwm_ref}, 32'd1);
    check("t2_no_early_ack", 32'(ack_cnt), 32'd0);
    advance_to('h600, 0, 9000, "t2_reach_600_down");
    check("t2_new_duty_ref", {31'd0, pwm_ref}, 32'd0);
    check("t2_ack_once", 32'(ack_cnt), 32'd1);

    // T3: reference pulse of 5 clocks, shorter than the dead time.
    carrier = 12'h500;
    repeat (20) step();
    check("t3_lo_before", {31'd0, out_lo}, 32'd1);
    lo_low = 0; hi_seen = 0;
    carrier = 12'h300;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) carrier = 12'h500;
      step();
      if (out_lo !== 1'b1) lo_low++;
      if (out_hi === 1'b1) hi_seen++;
    end
    check("t3_lo_gap", 32'(lo_low), 32'd5);
    check("t3_hi_never", 32'(hi_seen), 32'd0);
    check("t3_lo_after", {31'd0, out_lo}, 32'd1);

    // T4: rollover step must not look like a valley.
    carrier = 12'h000; repeat (2) step();
    carrier = 12'h001; repeat (2) step();
    ack_cnt = 0; sync_cnt = 0;
    carrier = 12'h002; duty_in = 12'h900; duty_valid = 1; step();
    duty_valid = 0; step();
    carrier = 12'hFFE; repeat (4) step();
    check("t4_no_sync", 32'(sync_cnt), 32'd0);
    check("t4_no_xfer", 32'(ack_cnt), 32'd0);
    carrier = 12'hFFD; step();
    check("t4_dir_held_peak_ack", {31'd0, duty_ack}, 32'd1);
    check("t4_ref_at_top", {31'd0, pwm_ref}, 32'd0);

    // T5: asynchronous reset while the high side is on.
    carrier = 12'h100;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = (out_hi === 1'b1); end
    check("t5_hi_reached", {31'd0, found}, 32'd1);
    step();
    #2 rst = 1;
    #1;
    check("t5_async_hi", {31'd0, out_hi}, 32'd0);
    check("t5_async_lo", {31'd0, out_lo}, 32'd0);
    model_reset();
    repeat (2) step();
    rst = 0;
    zeros = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (out_lo === 1'b1) found = 1; else zeros++;
    end
    check("t5_lo_reached", {31'd0, found}, 32'd1);
    check("t5_dead_after_reset", 32'(zeros), 32'(DEAD));

    // T6: zero duty keeps low side on; enable drop clears both next edge.
    duty_in = 12'h000; duty_valid = 1; step();
    duty_valid = 0; step();
    carrier = 12'h0F0; step();
    lo_on = 0; ref_ones = 0;
    for (int i = 0; i < 40; i++) begin
      carrier = 12'($urandom_range(0, 4095));
      step();
      if (i >= 20 && out_lo === 1'b1) lo_on++;
      if (pwm_ref !== 1'b0) ref_ones++;
    end
    check("t6_lo_steady", 32'(lo_on), 32'd20);
    check("t6_ref_zero", 32'(ref_ones), 32'd0);
    enable = 0; step();
    check("t6_off_hi", {31'd0, out_hi}, 32'd0);
    check("t6_off_lo", {31'd0, out_lo}, 32'd0);

    // Randomised run: varying slopes, rollovers, duty writes and enable drops.
    enable = 1; dis_left = 0;
    tri_val = int'(carrier); tri_up = 1; tri_step = 16; tri_hold = 1; tri_top = 4095; hold_cnt = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        tri_step = int'($urandom_range(1, 64));
        tri_hold = int'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 299) == 0) tri_val = int'($urandom_range(0, 4095));
      duty_valid = 0;
      if ($urandom_range(0, 49) == 0) begin
        duty_valid = 1;
        pick = int'($urandom_range(0, 3));
        duty_in = (pick == 0) ? 12'h000 : (pick == 1) ? 12'hFFF : 12'($urandom_range(0, 4095));
      end
      if (dis_left > 0) begin
        dis_left--;
        if (dis_left == 0) enable = 1;
      end else if ($urandom_range(0, 499) == 0) begin
        enable = 0;
        dis_left = int'($urandom_range(1, 20));
      end
      tick();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
